// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch stage's control inputs, instruction-memory port
// and IF/ID outputs.
//   master : fetch_unit side (drives imem_addr and the IF/ID outputs)
//   slave  : pipeline/memory side (drives the controls and imem_rdata)
// Signals: stall, branch, branch_addr, rti, int_req, imem_addr, imem_rdata,
//          if_instr, if_pc, if_valid, int_ack, busy.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 16,
  parameter int unsigned BR_W   = 16
);
  logic              stall;
  logic              branch;
  logic [BR_W-1:0]   branch_addr;
  logic              rti;
  logic              int_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic [INST_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              int_ack;
  logic              busy;

  modport master (
    input  stall, branch, branch_addr, rti, int_req, imem_rdata,
    output imem_addr, if_instr, if_pc, if_valid, int_ack, busy
  );

  modport slave (
    output stall, branch, branch_addr, rti, int_req, imem_rdata,
    input  imem_addr, if_instr, if_pc, if_valid, int_ack, busy
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, drives the instruction-memory
// address combinationally from it and registers the returned word into IF/ID.
// Handles stall, branch redirect (with one-bubble flush) and, when FETCH_INT_EN is
// defined, an interrupt-entry FSM (RUN -> DRAIN -> VECTOR) that saves the return PC
// in epc, inserts DRAIN_CYC bubbles, then vectors to INT_VEC; rti resumes at epc.
// Without FETCH_INT_EN, int_req/rti are ignored and int_ack/busy are tied low.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : fetch_unit_if.master (controls, imem port, IF/ID register outputs)
module fetch_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       INST_W    = 16,
  parameter int unsigned       BR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'(2),
  parameter int unsigned       DRAIN_CYC = 3
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              if_valid_q, if_valid_d;
  logic [BR_W-1:0]   br_raw;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_inc;

  assign br_raw    = bus.branch_addr;
  // Signed size cast sign-extends the branch offset to the PC width.
  assign br_target = ADDR_W'($signed(br_raw));
  assign pc_inc    = pc_q + ADDR_W'(1);

  assign bus.imem_addr = pc_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_valid  = if_valid_q;

`ifdef FETCH_INT_EN
  localparam int unsigned      CNT_W    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StVector
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              int_ack_q, int_ack_d;

  assign bus.int_ack = int_ack_q;
  assign bus.busy    = (state_q != StRun);

  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    state_d    = state_q;
    epc_d      = epc_q;
    cnt_d      = cnt_q;
    int_ack_d  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.branch) begin
          pc_d       = br_target;
          if_valid_d = 1'b0;
        end else if (bus.rti) begin
          pc_d       = epc_q;
          if_valid_d = 1'b0;
        end else if (bus.stall) begin
          // hold PC and IF/ID
        end else if (bus.int_req) begin
          epc_d      = pc_q;
          if_valid_d = 1'b0;
          cnt_d      = CNT_INIT;
          state_d    = StDrain;
        end else begin
          if_instr_d = bus.imem_rdata;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_inc;
        end
      end
      StDrain: begin
        if_valid_d = 1'b0;
        // An older instruction resolved a branch: return there, not to the saved PC.
        if (bus.branch) begin
          epc_d = br_target;
        end
        if (!bus.stall) begin
          if (cnt_q == '0) begin
            state_d = StVector;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      StVector: begin
        pc_d       = INT_VEC;
        int_ack_d  = 1'b1;
        if_valid_d = 1'b0;
        state_d    = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StRun;
      epc_q     <= '0;
      cnt_q     <= '0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      cnt_q     <= cnt_d;
      int_ack_q <= int_ack_d;
    end
  end
`else
  logic unused_int;
  assign unused_int  = ^{bus.int_req, bus.rti, INT_VEC, DRAIN_CYC};
  assign bus.int_ack = 1'b0;
  assign bus.busy    = 1'b0;

  always_comb begin
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    if (bus.branch) begin
      pc_d       = br_target;
      if_valid_d = 1'b0;
    end else if (!bus.stall) begin
      if_instr_d = bus.imem_rdata;
      if_pc_d    = pc_q;
      if_valid_d = 1'b1;
      pc_d       = pc_inc;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VEC;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Memory model: word at address k is 16'h1000 + k[15:0].
// Interrupt scenarios run when FETCH_INT_EN is defined; otherwise the bench checks
// that int_req/rti are ignored.
module tb_fetch_unit;
  logic clk;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  fetch_unit_if #(.ADDR_W(32), .INST_W(16), .BR_W(16)) bus ();

  fetch_unit #(
    .ADDR_W   (32),
    .INST_W   (16),
    .BR_W     (16),
    .RESET_VEC(32'h0),
    .INT_VEC  (32'h2),
    .DRAIN_CYC(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.imem_rdata = 16'h1000 + bus.imem_addr[15:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus.if_valid !== 1'b0) $display("FAIL reset if_valid: got %b want 0", bus.if_valid); else passes++;
    checks++; if (bus.if_pc !== 32'h0) $display("FAIL reset if_pc: got %h want 0", bus.if_pc); else passes++;
    checks++; if (bus.if_instr !== 16'h0) $display("FAIL reset if_instr: got %h want 0", bus.if_instr); else passes++;
    checks++; if (bus.imem_addr !== 32'h0) $display("FAIL reset imem_addr: got %h want 0", bus.imem_addr); else passes++;
    checks++; if (bus.int_ack !== 1'b0) $display("FAIL reset int_ack: got %b want 0", bus.int_ack); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b want 0", bus.busy); else passes++;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (bus.if_pc !== 32'(k)) $display("FAIL seq if_pc[%0d]: got %h want %h", k, bus.if_pc, 32'(k)); else passes++;
      checks++; if (bus.if_instr !== 16'h1000 + 16'(k)) $display("FAIL seq if_instr[%0d]: got %h want %h", k, bus.if_instr, 16'h1000 + 16'(k)); else passes++;
      checks++; if (bus.if_valid !== 1'b1) $display("FAIL seq if_valid[%0d]: got %b want 1", k, bus.if_valid); else passes++;
    end
    checks++; if (bus.imem_addr !== 32'h3) $display("FAIL seq imem_addr: got %h want 3", bus.imem_addr); else passes++;
  endtask

  task automatic test_branch_wrap();
    bus.branch = 1'b1; bus.branch_addr = 16'hFFFE;
    step();
    bus.branch = 1'b0; bus.branch_addr = '0;
    checks++; if (bus.if_valid !== 1'b0) $display("FAIL br bubble if_valid: got %b want 0", bus.if_valid); else passes++;
    checks++; if (bus.if_pc !== 32'h2) $display("FAIL br hold if_pc: got %h want 2", bus.if_pc); else passes++;
    checks++; if (bus.if_instr !== 16'h1002) $display("FAIL br hold if_instr: got %h want 1002", bus.if_instr); else passes++;
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFE) $display("FAIL br target pc: got %h want fffffffe", bus.imem_addr); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'hFFFF_FFFE || bus.if_valid !== 1'b1) $display("FAIL br fetch1 if_pc/valid: got %h/%b want fffffffe/1", bus.if_pc, bus.if_valid); else passes++;
    checks++; if (bus.if_instr !== 16'h0FFE) $display("FAIL br fetch1 if_instr: got %h want 0ffe", bus.if_instr); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'hFFFF_FFFF) $display("FAIL br fetch2 if_pc: got %h want ffffffff", bus.if_pc); else passes++;
    checks++; if (bus.imem_addr !== 32'h0) $display("FAIL br wrap pc: got %h want 0", bus.imem_addr); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 16'h1000) $display("FAIL br wrap fetch: got %h/%h want 0/1000", bus.if_pc, bus.if_instr); else passes++;
  endtask

  task automatic test_stall();
    bus.branch = 1'b1; bus.branch_addr = 16'h4;
    step();
    bus.branch = 1'b0;
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'h5) $display("FAIL stall pc[%0d]: got %h want 5", i, bus.imem_addr); else passes++;
      checks++; if (bus.if_pc !== 32'h4 || bus.if_instr !== 16'h1004 || bus.if_valid !== 1'b1)
        $display("FAIL stall ifid[%0d]: got %h/%h/%b want 4/1004/1", i, bus.if_pc, bus.if_instr, bus.if_valid);
      else passes++;
    end
    bus.branch = 1'b1; bus.branch_addr = 16'h20;
    step();
    bus.branch = 1'b0; bus.stall = 1'b0;
    checks++; if (bus.imem_addr !== 32'h20 || bus.if_valid !== 1'b0) $display("FAIL stall branch redirect: got %h/%b want 20/0", bus.imem_addr, bus.if_valid); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'h20 || bus.if_instr !== 16'h1020) $display("FAIL stall branch fetch: got %h/%h want 20/1020", bus.if_pc, bus.if_instr); else passes++;
  endtask

`ifdef FETCH_INT_EN
  task automatic test_interrupt();
    bus.branch = 1'b1; bus.branch_addr = 16'h8;
    step();
    bus.branch = 1'b0;
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.if_valid !== 1'b0 || bus.imem_addr !== 32'h8)
      $display("FAIL int accept busy/valid/pc: got %b/%b/%h want 1/0/8", bus.busy, bus.if_valid, bus.imem_addr);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.busy !== 1'b1 || bus.if_valid !== 1'b0 || bus.int_ack !== 1'b0 || bus.imem_addr !== 32'h8)
        $display("FAIL int drain[%0d] busy/valid/ack/pc: got %b/%b/%b/%h want 1/0/0/8", i, bus.busy, bus.if_valid, bus.int_ack, bus.imem_addr);
      else passes++;
    end
    step();
    checks++; if (bus.int_ack !== 1'b1 || bus.imem_addr !== 32'h2 || bus.busy !== 1'b0 || bus.if_valid !== 1'b0)
      $display("FAIL int vector ack/pc/busy/valid: got %b/%h/%b/%b want 1/2/0/0", bus.int_ack, bus.imem_addr, bus.busy, bus.if_valid);
    else passes++;
    step();
    checks++; if (bus.int_ack !== 1'b0) $display("FAIL int ack pulse width: got %b want 0", bus.int_ack); else passes++;
    checks++; if (bus.if_pc !== 32'h2 || bus.if_instr !== 16'h1002 || bus.if_valid !== 1'b1)
      $display("FAIL int handler fetch: got %h/%h/%b want 2/1002/1", bus.if_pc, bus.if_instr, bus.if_valid);
    else passes++;
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.imem_addr !== 32'h8 || bus.if_valid !== 1'b0) $display("FAIL rti pc/valid: got %h/%b want 8/0", bus.imem_addr, bus.if_valid); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'h8 || bus.if_instr !== 16'h1008) $display("FAIL rti resume: got %h/%h want 8/1008", bus.if_pc, bus.if_instr); else passes++;
  endtask

  task automatic test_drain_branch();
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    bus.branch = 1'b1; bus.branch_addr = 16'h40;
    step();
    bus.branch = 1'b0;
    checks++; if (bus.imem_addr !== 32'h9 || bus.busy !== 1'b1) $display("FAIL drain branch pc/busy: got %h/%b want 9/1", bus.imem_addr, bus.busy); else passes++;
    step();
    step();
    step();
    checks++; if (bus.int_ack !== 1'b1 || bus.imem_addr !== 32'h2) $display("FAIL drain branch vector: got %b/%h want 1/2", bus.int_ack, bus.imem_addr); else passes++;
    step();
    bus.rti = 1'b1;
    step();
    bus.rti = 1'b0;
    checks++; if (bus.imem_addr !== 32'h40) $display("FAIL drain branch epc: got %h want 40", bus.imem_addr); else passes++;
    step();
    checks++; if (bus.if_pc !== 32'h40 || bus.if_instr !== 16'h1040) $display("FAIL drain branch resume: got %h/%h want 40/1040", bus.if_pc, bus.if_instr); else passes++;
  endtask

  task automatic test_reset_drain();
    bus.int_req = 1'b1;
    step();
    bus.int_req = 1'b0;
    step();
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.imem_addr !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0)
      $display("FAIL rst drain state: got %b/%h/%b/%h want 0/0/0/0", bus.busy, bus.imem_addr, bus.if_valid, bus.if_pc);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (bus.int_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst drain ack/busy[%0d]: got %b/%b want 0/0", i, bus.int_ack, bus.busy); else passes++;
    end
    reset = 1'b0;
    step();
    checks++; if (bus.if_pc !== 32'h0 || bus.if_instr !== 16'h1000 || bus.if_valid !== 1'b1 || bus.int_ack !== 1'b0)
      $display("FAIL rst drain restart: got %h/%h/%b/%b want 0/1000/1/0", bus.if_pc, bus.if_instr, bus.if_valid, bus.int_ack);
    else passes++;
  endtask
`else
  task automatic test_int_ignored();
    bus.int_req = 1'b1;
    bus.rti     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.if_pc !== 32'h21 + 32'(i) || bus.if_instr !== 16'h1021 + 16'(i) || bus.if_valid !== 1'b1)
        $display("FAIL noint seq[%0d]: got %h/%h/%b want %h/%h/1", i, bus.if_pc, bus.if_instr, bus.if_valid, 32'h21 + 32'(i), 16'h1021 + 16'(i));
      else passes++;
      checks++; if (bus.int_ack !== 1'b0 || bus.busy !== 1'b0) $display("FAIL noint ack/busy[%0d]: got %b/%b want 0/0", i, bus.int_ack, bus.busy); else passes++;
    end
    bus.int_req = 1'b0;
    bus.rti     = 1'b0;
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus.stall       = 1'b0;
    bus.branch      = 1'b0;
    bus.branch_addr = '0;
    bus.rti         = 1'b0;
    bus.int_req     = 1'b0;
    #12;
    test_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    test_sequential();
    test_branch_wrap();
    test_stall();
`ifdef FETCH_INT_EN
    test_interrupt();
    test_drain_branch();
    test_reset_drain();
`else
    test_int_ignored();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
